// File: rtl/light_pkg.sv
// light_pkg: shared FSM type and constants for the light sensor scheduler.
// Used by light_sched and light_avg.
package light_pkg;

  localparam int SAMPLE_W     = 8;
  localparam int DEF_INTERVAL = 1000;
  localparam int DEF_TIMEOUT  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_CONVERT,
    S_FILTER,
    S_PUSH
  } state_t;

endpackage

// File: rtl/light_avg.sv
// light_avg: ring buffer plus running sum giving a 2**AVG_LOG2 moving average.
// init seeds every entry with the sample so the first average equals it.
module light_avg
  import light_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                init,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW    = SAMPLE_W + AVG_LOG2;

  logic [SAMPLE_W-1:0] r_buf [DEPTH];
  logic [PW-1:0]       r_ptr;
  logic [SW-1:0]       r_sum;
  logic [SW-1:0]       w_sum_nxt;
  logic [PW-1:0]       w_ptr_nxt;

  // r_ptr always points at the oldest entry
  always_comb begin
    w_sum_nxt = r_sum - SW'(r_buf[r_ptr]) + SW'(sample);
    w_ptr_nxt = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (load) begin
      if (init) begin
        for (int i = 0; i < DEPTH; i++) r_buf[i] <= sample;
        r_sum <= SW'(sample) << AVG_LOG2;
        r_ptr <= '0;
      end else begin
        r_buf[r_ptr] <= sample;
        r_sum        <= w_sum_nxt;
        r_ptr        <= w_ptr_nxt;
      end
    end
  end

  assign avg = r_sum[SW-1:AVG_LOG2];

endmodule

// File: rtl/light_sched.sv
// light_sched: periodic light-sensor conversion, averaging and duty handoff.
// Define LIGHT_SCHED_INVERT_EN to output duty = 255 - avg.
module light_sched
  import light_pkg::*;
#(
  parameter int INTERVAL = DEF_INTERVAL,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                err_clr,
  output logic                conv_start,
  input  logic                conv_done,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] duty,
  output logic                duty_valid,
  input  logic                duty_ready,
  output logic                timeout_err,
  output logic                busy
);

  localparam int IW = $clog2(INTERVAL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_nstate;
  logic [IW-1:0]       r_icnt;
  logic [IW-1:0]       w_icnt;
  logic [IW-1:0]       w_icnt_run;
  logic [TW-1:0]       r_tcnt;
  logic [TW-1:0]       w_tcnt;
  logic                w_iexp;
  logic                w_start;
  logic                w_accept;
  logic                w_tout;
  logic                w_push;
  logic                w_pop;
  logic                r_first;
  logic                r_conv_start;
  logic [SAMPLE_W-1:0] r_duty;
  logic                r_duty_valid;
  logic                r_terr;
  logic [SAMPLE_W-1:0] w_avg;
  logic [SAMPLE_W-1:0] w_map;

  light_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_accept),
    .init   (r_first),
    .sample (sample),
    .avg    (w_avg)
  );

`ifdef LIGHT_SCHED_INVERT_EN
  assign w_map = 8'hFF - w_avg;
`else
  assign w_map = w_avg;
`endif

  assign w_iexp     = (r_icnt == IW'(INTERVAL - 1));
  assign w_icnt_run = w_iexp ? '0 : r_icnt + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_icnt  <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_nstate;
      r_icnt  <= w_icnt;
      r_tcnt  <= w_tcnt;
    end
  end

  // Only WAIT_TICK can fire a tick; expiries elsewhere just wrap
  always_comb begin
    w_nstate = r_state;
    w_icnt   = r_icnt;
    w_tcnt   = r_tcnt;
    w_start  = 1'b0;
    w_accept = 1'b0;
    w_tout   = 1'b0;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_nstate = S_WAIT_TICK;
          w_icnt   = '0;
        end
      end
      S_WAIT_TICK: begin
        w_icnt = w_icnt_run;
        if (!enable) begin
          w_nstate = S_IDLE;
          w_icnt   = '0;
        end else if (w_iexp) begin
          w_nstate = S_CONVERT;
          w_start  = 1'b1;
          w_tcnt   = '0;
        end
      end
      S_CONVERT: begin
        w_icnt = w_icnt_run;
        w_tcnt = r_tcnt + TW'(1);
        if (conv_done) begin
          w_nstate = S_FILTER;
          w_accept = 1'b1;
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_tout   = 1'b1;
          w_icnt   = '0;
          w_nstate = enable ? S_WAIT_TICK : S_IDLE;
        end
      end
      S_FILTER: begin
        w_icnt   = w_icnt_run;
        w_push   = 1'b1;
        w_nstate = S_PUSH;
      end
      S_PUSH: begin
        w_icnt = w_icnt_run;
        if (r_duty_valid && duty_ready) begin
          w_pop    = 1'b1;
          w_nstate = enable ? S_WAIT_TICK : S_IDLE;
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_icnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_start <= 1'b0;
      r_duty       <= '0;
      r_duty_valid <= 1'b0;
      r_terr       <= 1'b0;
      r_first      <= 1'b1;
    end else begin
      r_conv_start <= w_start;
      if (w_push) begin
        r_duty       <= w_map;
        r_duty_valid <= 1'b1;
      end else if (w_pop) begin
        r_duty_valid <= 1'b0;
      end
      // a fresh timeout wins over a same-cycle clear
      if (w_tout) r_terr <= 1'b1;
      else if (err_clr) r_terr <= 1'b0;
      if (w_accept) r_first <= 1'b0;
    end
  end

  assign conv_start  = r_conv_start;
  assign duty        = r_duty;
  assign duty_valid  = r_duty_valid;
  assign timeout_err = r_terr;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_light_sched.sv
// tb_light_sched: randomized and directed checks of light_sched
// against a queue-based moving-average model.
module tb_light_sched;

  localparam int INTERVAL = 100;
  localparam int TIMEOUT  = 64;
  localparam int AVG_LOG2 = 2;
  localparam int DEPTH    = 1 << AVG_LOG2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       err_clr = 1'b0;
  logic       conv_start;
  logic       conv_done = 1'b0;
  logic [7:0] sample = 8'h00;
  logic [7:0] duty;
  logic       duty_valid;
  logic       duty_ready = 1'b1;
  logic       timeout_err;
  logic       busy;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] m_hist [$];

  light_sched #(
    .INTERVAL (INTERVAL),
    .TIMEOUT  (TIMEOUT),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .err_clr     (err_clr),
    .conv_start  (conv_start),
    .conv_done   (conv_done),
    .sample      (sample),
    .duty        (duty),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_map(input int a);
`ifdef LIGHT_SCHED_INVERT_EN
    return 8'(255 - a);
`else
    return 8'(a);
`endif
  endfunction

  // Model: average of the last DEPTH accepted samples,
  // history pre-filled with the first sample.
  function automatic logic [7:0] m_accept(input logic [7:0] s);
    int sum;
    if (m_hist.size() == 0) begin
      for (int i = 0; i < DEPTH; i++) m_hist.push_back(s);
    end else begin
      m_hist.push_back(s);
      void'(m_hist.pop_front());
    end
    sum = 0;
    foreach (m_hist[i]) sum += int'(m_hist[i]);
    return exp_map(sum / DEPTH);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    conv_done = 1'b0;
    err_clr = 1'b0;
    duty_ready = 1'b1;
    sample = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_hist.delete();
  endtask

  task automatic wait_start(input int budget, output int t, output bit got);
    got = 1'b0;
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (conv_start === 1'b1) begin
        got = 1'b1;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic respond(input logic [7:0] s, input int dly);
    repeat (dly) @(negedge clk);
    conv_done = 1'b1;
    sample = s;
    @(negedge clk);
    conv_done = 1'b0;
    sample = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (conv_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_conv_start got %b want 0", conv_start);
    end
    n_tests++;
    if (duty !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_duty got %h want 00", duty);
    end
    n_tests++;
    if (duty_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_duty_valid got %b want 0", duty_valid);
    end
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_timeout_err got %b want 0", timeout_err);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_periodic();
    int t, tp, e, et;
    bit got;
    logic [7:0] ed;
    do_reset();
    enable = 1'b1;
    e = cyc;
    tp = 0;
    for (int k = 0; k < 3; k++) begin
      wait_start(250, t, got);
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL per_start%0d got none want pulse", k);
        return;
      end
      et = (k == 0) ? e + INTERVAL + 1 : tp + INTERVAL;
      n_tests++;
      if (t !== et) begin
        n_fail++;
        $display("FAIL per_time%0d got %0d want %0d", k, t, et);
      end
      tp = t;
      respond(8'h80, 3);
      n_tests++;
      if (duty_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL per_early%0d got %b want 0", k, duty_valid);
      end
      @(negedge clk);
      ed = m_accept(8'h80);
      n_tests++;
      if (duty_valid !== 1'b1 || duty !== ed) begin
        n_fail++;
        $display("FAIL per_duty%0d got %b/%h want 1/%h",
                 k, duty_valid, duty, ed);
      end
    end
  endtask

  task automatic test_sequence();
    logic [7:0] smp [5] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    int avg [5] = '{128, 96, 64, 32, 0};
    int t;
    bit got;
    logic [7:0] e;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_start(250, t, got);
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL seq_start%0d got none want pulse", i);
        return;
      end
      respond(smp[i], 2);
      @(negedge clk);
      e = exp_map(avg[i]);
      void'(m_accept(smp[i]));
      n_tests++;
      if (duty_valid !== 1'b1 || duty !== e) begin
        n_fail++;
        $display("FAIL seq_duty%0d got %b/%h want 1/%h",
                 i, duty_valid, duty, e);
      end
    end
  endtask

  task automatic test_timeout();
    int t, t2, t3, dv;
    bit got;
    logic [7:0] e;
    do_reset();
    enable = 1'b1;
    dv = 0;
    wait_start(250, t, got);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL to_start got none want pulse");
      return;
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (duty_valid !== 1'b0) dv++;
      if (k == TIMEOUT - 1) begin
        n_tests++;
        if (timeout_err !== 1'b0) begin
          n_fail++;
          $display("FAIL to_early got %b want 0", timeout_err);
        end
      end
      if (k == TIMEOUT) begin
        n_tests++;
        if (timeout_err !== 1'b1) begin
          n_fail++;
          $display("FAIL to_set got %b want 1", timeout_err);
        end
      end
    end
    wait_start(250, t2, got);
    n_tests++;
    if (!got || t2 !== t + TIMEOUT + INTERVAL) begin
      n_fail++;
      $display("FAIL to_resched got %0d want %0d",
               t2, t + TIMEOUT + INTERVAL);
      return;
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (duty_valid !== 1'b0) dv++;
      if (k == TIMEOUT - 1) begin
        n_tests++;
        if (timeout_err !== 1'b1) begin
          n_fail++;
          $display("FAIL to_sticky got %b want 1", timeout_err);
        end
        err_clr = 1'b1;
      end
      if (k == TIMEOUT) begin
        err_clr = 1'b0;
        n_tests++;
        if (timeout_err !== 1'b1) begin
          n_fail++;
          $display("FAIL to_clr_race got %b want 1", timeout_err);
        end
      end
    end
    n_tests++;
    if (dv !== 0) begin
      n_fail++;
      $display("FAIL to_no_valid got %0d want 0", dv);
    end
    wait_start(250, t3, got);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL to_start3 got none want pulse");
      return;
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_clear got %b want 0", timeout_err);
    end
    conv_done = 1'b1;
    sample = 8'h20;
    @(negedge clk);
    conv_done = 1'b0;
    @(negedge clk);
    e = m_accept(8'h20);
    n_tests++;
    if (duty_valid !== 1'b1 || duty !== e) begin
      n_fail++;
      $display("FAIL to_after got %b/%h want 1/%h",
               duty_valid, duty, e);
    end
  endtask

  task automatic test_backpressure();
    int t, t2, bad, st;
    bit got;
    logic [7:0] e;
    do_reset();
    enable = 1'b1;
    duty_ready = 1'b0;
    wait_start(250, t, got);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL bp_start got none want pulse");
      return;
    end
    respond(8'h5A, 3);
    e = m_accept(8'h5A);
    bad = 0;
    st = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (duty_valid !== 1'b1 || duty !== e) bad++;
      if (conv_start !== 1'b0) st++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_stable got %0d bad want 0", bad);
    end
    n_tests++;
    if (st !== 0) begin
      n_fail++;
      $display("FAIL bp_dropped got %0d starts want 0", st);
    end
    @(negedge clk);
    duty_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (duty_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_pop got %b want 0", duty_valid);
    end
    wait_start(150, t2, got);
    n_tests++;
    if (!got || t2 !== t + 3 * INTERVAL) begin
      n_fail++;
      $display("FAIL bp_next got %0d want %0d", t2, t + 3 * INTERVAL);
    end
  endtask

  task automatic test_reset_mid();
    int t, bad;
    bit got;
    logic [7:0] e;
    do_reset();
    enable = 1'b1;
    wait_start(250, t, got);
    respond(8'h80, 3);
    @(negedge clk);
    wait_start(250, t, got);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL rm_start got none want pulse");
      return;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (duty !== 8'h00 || duty_valid !== 1'b0 || busy !== 1'b0 ||
        timeout_err !== 1'b0 || conv_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_outs got %h/%b/%b/%b/%b want 00/0/0/0/0",
               duty, duty_valid, busy, timeout_err, conv_start);
    end
    m_hist.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    conv_done = 1'b1;
    sample = 8'h33;
    @(negedge clk);
    conv_done = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (duty_valid !== 1'b0 || duty !== 8'h00) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rm_ignored got %0d bad want 0", bad);
    end
    wait_start(250, t, got);
    respond(8'h44, 3);
    @(negedge clk);
    e = m_accept(8'h44);
    n_tests++;
    if (duty_valid !== 1'b1 || duty !== e) begin
      n_fail++;
      $display("FAIL rm_first got %b/%h want 1/%h", duty_valid, duty, e);
    end
  endtask

  task automatic test_enable_drop();
    int t, bad;
    bit got;
    logic [7:0] e;
    do_reset();
    enable = 1'b1;
    wait_start(250, t, got);
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL ed_start got none want pulse");
      return;
    end
    @(negedge clk);
    enable = 1'b0;
    respond(8'h10, 1);
    @(negedge clk);
    e = m_accept(8'h10);
    n_tests++;
    if (duty_valid !== 1'b1 || duty !== e) begin
      n_fail++;
      $display("FAIL ed_duty got %b/%h want 1/%h", duty_valid, duty, e);
    end
    @(negedge clk);
    n_tests++;
    if (duty_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ed_idle got %b/%b want 0/0", duty_valid, busy);
    end
    bad = 0;
    repeat (250) begin
      @(negedge clk);
      if (conv_start !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL ed_quiet got %0d bad want 0", bad);
    end
  endtask

  task automatic test_random();
    int t, tp, dly, r, bad;
    bit got;
    logic [7:0] s, e;
    do_reset();
    enable = 1'b1;
    duty_ready = 1'b0;
    tp = -1;
    for (int it = 0; it < 12; it++) begin
      s = 8'($urandom);
      dly = $urandom_range(1, 20);
      r = $urandom_range(0, 5);
      wait_start(250, t, got);
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL rnd_start%0d got none want pulse", it);
        return;
      end
      if (tp >= 0) begin
        n_tests++;
        if (t - tp !== INTERVAL) begin
          n_fail++;
          $display("FAIL rnd_period%0d got %0d want %0d",
                   it, t - tp, INTERVAL);
        end
      end
      tp = t;
      respond(s, dly);
      @(negedge clk);
      e = m_accept(s);
      n_tests++;
      if (duty_valid !== 1'b1 || duty !== e) begin
        n_fail++;
        $display("FAIL rnd_duty%0d got %b/%h want 1/%h",
                 it, duty_valid, duty, e);
      end
      bad = 0;
      repeat (r) begin
        @(negedge clk);
        if (duty_valid !== 1'b1 || duty !== e) bad++;
      end
      duty_ready = 1'b1;
      @(negedge clk);
      duty_ready = 1'b0;
      n_tests++;
      if (duty_valid !== 1'b0 || bad !== 0) begin
        n_fail++;
        $display("FAIL rnd_hs%0d got %b/%0d want 0/0",
                 it, duty_valid, bad);
      end
      conv_done = 1'b1;
      sample = 8'($urandom);
      @(negedge clk);
      conv_done = 1'b0;
    end
    enable = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_periodic();
    test_sequence();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
